// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: drives the ROM address from the next pc and tracks the in-flight fetch.
// It delivers inst/inst_pc with one cycle of latency. On a stall it replays the held word, on a
// flush it inserts a bubble, and it flags fetches whose address is outside the ROM.
module inst_fetch_stage #(
  parameter int unsigned ADDR_W = 14,
  parameter logic [31:0] NOP    = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  output logic              addr_fault,
  output logic [31:0]       fetch_count
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    SQUASH = 2'd3
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   fetch_pc_q;
  logic [DATA_W-1:0]   hold_inst_q;
  logic [DATA_W-1:0]   hold_pc_q;
  logic                hold_valid_q;
  logic                fault_q;
  logic [DATA_W-1:0]   count_q;
  logic [DATA_W-1:0]   count_d;
  logic                out_of_range;

  // ROM address is a plain truncation of the next pc, independent of state and reset.
  assign imem_addr    = pc[ADDR_W-1:0];
  assign out_of_range = (pc >> ADDR_W) != '0;
  assign count_d      = count_q + DATA_W'(1);

  assign addr_fault  = fault_q;
  assign fetch_count = count_q;

  // Delivered word depends only on state, held registers and ROM data (no stall/flush path).
  always_comb begin
    inst       = NOP;
    inst_pc    = fetch_pc_q;
    inst_valid = 1'b0;
    case (state_q)
      RUN: begin
        inst       = imem_rdata;
        inst_pc    = fetch_pc_q;
        inst_valid = 1'b1;
      end
      HOLD: begin
        inst       = hold_inst_q;
        inst_pc    = hold_pc_q;
        inst_valid = hold_valid_q;
      end
      default: begin
        inst       = NOP;
        inst_pc    = fetch_pc_q;
        inst_valid = 1'b0;
      end
    endcase
  end

  // Fetch FSM, in-flight pc, replay registers, sticky fault and delivered-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      fetch_pc_q   <= '0;
      hold_inst_q  <= NOP;
      hold_pc_q    <= '0;
      hold_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      if (!stall) begin
        fetch_pc_q <= pc;
      end
      if (!stall && out_of_range) begin
        fault_q <= 1'b1;
      end
      // A replayed word is counted once, on the cycle its stall drops.
      if (inst_valid && !stall) begin
        count_q <= count_d;
      end
      if (flush) begin
        state_q <= SQUASH;
      end else if (stall) begin
        // Entering HOLD freezes whatever is on the outputs now, including a bubble.
        if (state_q != HOLD) begin
          hold_inst_q  <= inst;
          hold_pc_q    <= inst_pc;
          hold_valid_q <= inst_valid;
        end
        state_q <= HOLD;
      end else begin
        state_q <= RUN;
      end
    end
  end

endmodule
